// File: rtl/seg_display_monitor.sv
// Seven-segment display monitor: snoops a multiplexed active-low anode/segment
// bus, commits stable digits per position, and flags illegal patterns and
// multi-anode collisions.
// Optional build macro SEG_MON_HEX_EN: also decode A-F glyphs as legal values.
module seg_display_monitor #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an_in,
    input  logic [6:0]  seg_in,
    input  logic        err_clr,
    output logic [31:0] digits_out,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        err_flag,
    output logic [1:0]  err_code,
    output logic [2:0]  err_digit
);

    typedef enum logic [1:0] {
        DecLegal   = 2'd0,
        DecBlank   = 2'd1,
        DecIllegal = 2'd2
    } dec_kind_e;

    localparam logic [7:0] StableTarget = 8'(STABLE_CYCLES);

    logic [7:0]  an_q, an_prev;
    logic [6:0]  seg_q, seg_prev;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] digits_d;
    logic [7:0]  valid_d;
    logic        frame_d, flag_d;
    logic [1:0]  code_d;
    logic [2:0]  edig_d;
    logic        same, active, multi, stable_hit, commit, multi_err;
    logic [3:0]  zeros;
    logic [2:0]  pos;
    dec_kind_e   dec_kind;
    logic [3:0]  dec_val;
    logic [7:0]  mask_set;

    // Input capture plus one-cycle-delayed copy for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            an_prev  <= 8'hFF;
            seg_prev <= 7'h7F;
        end else begin
            an_q     <= an_in;
            seg_q    <= seg_in;
            an_prev  <= an_q;
            seg_prev <= seg_q;
        end
    end

    // Classify the registered anode sample and locate the selected position.
    always_comb begin
        zeros = 4'd0;
        pos   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            zeros = zeros + {3'b000, ~an_q[i]};
            if (!an_q[i]) pos = 3'(i);
        end
        active = (zeros == 4'd1);
        multi  = (zeros > 4'd1);
    end

    // Segment decode; blank is distinguished from illegal.
    always_comb begin
        dec_kind = DecLegal;
        dec_val  = 4'hE;
        unique case (seg_q)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
`ifdef SEG_MON_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
`endif
            7'b1111111: begin
                dec_kind = DecBlank;
                dec_val  = 4'hF;
            end
            default: begin
                dec_kind = DecIllegal;
                dec_val  = 4'hE;
            end
        endcase
    end

    // Dwell counter; a hit fires once when the count first reaches the target.
    always_comb begin
        same = (an_q == an_prev) && (seg_q == seg_prev);
        if (same) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        else      cnt_d = 8'd1;
        // Once saturated at the target the count stops moving, so require movement.
        stable_hit = (cnt_d == StableTarget) && (!same || (cnt_q != cnt_d));
        commit     = stable_hit && active;
        multi_err  = stable_hit && multi;
    end

    // Next-state for digit store, frame mask and error reporting.
    always_comb begin
        digits_d = digits_out;
        valid_d  = digit_valid;
        mask_d   = mask_q;
        frame_d  = 1'b0;
        flag_d   = err_flag;
        code_d   = err_code;
        edig_d   = err_digit;
        mask_set = mask_q | (8'd1 << pos);

        if (err_clr) begin
            flag_d = 1'b0;
            code_d = 2'b00;
        end

        if (commit) begin
            digits_d[pos*4 +: 4] = dec_val;
            valid_d[pos]         = (dec_kind == DecLegal);
            if (dec_kind == DecIllegal) begin
                flag_d = 1'b1;
                code_d = 2'b01;
                edig_d = pos;
            end
            if (mask_set == 8'hFF) begin
                mask_d  = 8'h00;
                frame_d = 1'b1;
            end else begin
                mask_d = mask_set;
            end
        end

        if (multi_err) begin
            flag_d = 1'b1;
            code_d = 2'b10;
        end
    end

    // Output and control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 8'd0;
            mask_q      <= 8'h00;
            digits_out  <= 32'hFFFF_FFFF;
            digit_valid <= 8'h00;
            frame_done  <= 1'b0;
            err_flag    <= 1'b0;
            err_code    <= 2'b00;
            err_digit   <= 3'd0;
        end else begin
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            digits_out  <= digits_d;
            digit_valid <= valid_d;
            frame_done  <= frame_d;
            err_flag    <= flag_d;
            err_code    <= code_d;
            err_digit   <= edig_d;
        end
    end

endmodule
